radix2_divider: RTL and testbench

Iterative 32-bit restoring divider that serves the EX stage's `divide_valid` requests and returns quotient/remainder for the `divide_result`/`divide_remain` fields forwarded to IO and the HI/LO write path. It accepts one request at a time through a valid/ready handshake and uses a four-state FSM: WAITING, LOAD, DIVIDE, RETURN (`divider_params::State` encoding 00/01/10/11). It holds its result until EX consumes it and supports cancellation when the pipeline is flushed by an exception.

---
 rtl/radix2_divider.sv | 217 +++++++++++++++++++++
 tb/tb_radix2_divider.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/radix2_divider.sv
// radix2_divider: iterative 32-bit restoring divider for the EX stage.
//
// One request is handled at a time. Operands are captured at the accept edge,
// converted to magnitudes in LOAD, divided one quotient bit per cycle in
// DIVIDE, and sign-corrected on the DIVIDE->RETURN edge. The result is held in
// RETURN until EX takes it. A pipeline flush (cancel) aborts from any state.
//
// Optional build macro: DIVIDER_EARLY_FINISH_EN
//   When defined, LOAD jumps straight to RETURN if the divisor is zero or the
//   dividend magnitude is below the divisor magnitude. Results are identical
//   to the full-length path; only the latency changes.
//
// Handshake semantics (both channels): a transfer happens on a rising clock
// edge where valid and ready are both high. request_ready is high only in
// WAITING and result_valid is high only in RETURN; both are decodes of the
// state register with no combinational path from any input. The requester may
// drop or change request_valid/operands freely while request_ready is low.
// Once result_valid is high, quotient/remainder stay stable until the result
// transfer or a cancel. cancel wins over both an accept and a result transfer.

module radix2_divider #(
    parameter int CPU_DATA_WIDTH = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      request_valid,
    output logic                      request_ready,
    input  logic                      request_signed,
    input  logic [CPU_DATA_WIDTH-1:0] dividend,
    input  logic [CPU_DATA_WIDTH-1:0] divisor,
    input  logic                      cancel,
    output logic                      result_valid,
    input  logic                      result_ready,
    output logic [CPU_DATA_WIDTH-1:0] quotient,
    output logic [CPU_DATA_WIDTH-1:0] remainder,
    output logic                      busy
);

    localparam int W  = CPU_DATA_WIDTH;
    localparam int CW = $clog2(W);

    // State encoding shared with divider_params::State.
    localparam logic [1:0] S_WAITING = 2'b00;
    localparam logic [1:0] S_LOAD    = 2'b01;
    localparam logic [1:0] S_DIVIDE  = 2'b10;
    localparam logic [1:0] S_RETURN  = 2'b11;

    logic [1:0]      state;

    // Operands as captured at the accept edge.
    logic [W-1:0]    op_dividend;
    logic [W-1:0]    op_divisor;
    logic            op_signed;

    // Iteration datapath.
    logic [W-1:0]    dvs_mag;
    logic [2*W-1:0]  partial;
    logic [CW-1:0]   count;
    logic            q_neg;
    logic            r_neg;

    // Combinational helpers.
    logic            accept;
    logic            last_iter;
    logic            div_zero;
    logic [W-1:0]    dvd_abs;
    logic [W-1:0]    dvs_abs;
    logic [W:0]      trial_hi;
    logic            trial_ge;
    logic [W-1:0]    trial_diff;
    logic [2*W-1:0]  partial_next;
    logic [W-1:0]    q_mag;
    logic [W-1:0]    r_mag;
    logic [W-1:0]    q_final;
    logic [W-1:0]    r_final;
    logic            early_hit;

    assign request_ready = (state == S_WAITING);
    assign result_valid  = (state == S_RETURN);
    assign busy          = (state != S_WAITING);

    assign accept    = (state == S_WAITING) && request_valid && !cancel;
    assign last_iter = (state == S_DIVIDE) && (count == '0);
    assign div_zero  = (op_divisor == '0);

    // Operand magnitudes: two's complement negate only for negative signed values.
    always_comb begin
        dvd_abs = op_dividend;
        dvs_abs = op_divisor;
        if (op_signed && op_dividend[W-1]) begin
            dvd_abs = -op_dividend;
        end
        if (op_signed && op_divisor[W-1]) begin
            dvs_abs = -op_divisor;
        end
    end

    // One restoring step: the upper W+1 bits of the shifted partial remainder
    // are compared against the divisor magnitude. When the trial succeeds the
    // difference always fits in W bits, so the W-bit subtraction is exact.
    always_comb begin
        trial_hi     = partial[2*W-1:W-1];
        trial_ge     = (trial_hi >= {1'b0, dvs_mag});
        trial_diff   = trial_hi[W-1:0] - dvs_mag;
        partial_next = {partial[2*W-2:0], 1'b0};
        if (trial_ge) begin
            partial_next = {trial_diff, partial[W-2:0], 1'b1};
        end
    end

    // Sign correction applied to the final iteration's output. Divide by zero
    // bypasses it: all-ones quotient and the raw dividend as remainder.
    always_comb begin
        q_mag   = partial_next[W-1:0];
        r_mag   = partial_next[2*W-1:W];
        q_final = q_neg ? -q_mag : q_mag;
        r_final = r_neg ? -r_mag : r_mag;
        if (div_zero) begin
            q_final = '1;
            r_final = op_dividend;
        end
    end

`ifdef DIVIDER_EARLY_FINISH_EN
    // Trivial cases that need no iterations: x/0 or |dividend| < |divisor|.
    assign early_hit = div_zero || (dvd_abs < dvs_abs);
`else
    assign early_hit = 1'b0;
`endif

    // FSM: cancel and reset both force WAITING; otherwise advance per state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_WAITING;
        end else if (cancel) begin
            state <= S_WAITING;
        end else begin
            case (state)
                S_WAITING: begin
                    if (request_valid) begin
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (early_hit) begin
                        state <= S_RETURN;
                    end else begin
                        state <= S_DIVIDE;
                    end
                end
                S_DIVIDE: begin
                    if (count == '0) begin
                        state <= S_RETURN;
                    end
                end
                S_RETURN: begin
                    if (result_ready) begin
                        state <= S_WAITING;
                    end
                end
                default: begin
                    state <= S_WAITING;
                end
            endcase
        end
    end

    // Operand capture: inputs are only sampled on the accept edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            op_dividend <= '0;
            op_divisor  <= '0;
            op_signed   <= 1'b0;
        end else if (accept) begin
            op_dividend <= dividend;
            op_divisor  <= divisor;
            op_signed   <= request_signed;
        end
    end

    // Iteration datapath: initialised in LOAD, one shift/subtract per DIVIDE cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            dvs_mag <= '0;
            partial <= '0;
            count   <= '0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
        end else if (state == S_LOAD) begin
            dvs_mag <= dvs_abs;
            partial <= {{W{1'b0}}, dvd_abs};
            count   <= CW'(W - 1);
            q_neg   <= op_signed && (op_dividend[W-1] ^ op_divisor[W-1]);
            r_neg   <= op_signed && op_dividend[W-1];
        end else if (state == S_DIVIDE) begin
            partial <= partial_next;
            count   <= count - CW'(1);
        end
    end

    // Result registers: loaded on entry to RETURN, held until the next result.
    always_ff @(posedge clock) begin
        if (reset) begin
            quotient  <= '0;
            remainder <= '0;
        end else if (!cancel) begin
            if (last_iter) begin
                quotient  <= q_final;
                remainder <= r_final;
            end else if ((state == S_LOAD) && early_hit) begin
                quotient  <= div_zero ? {W{1'b1}} : {W{1'b0}};
                remainder <= op_dividend;
            end
        end
    end

endmodule

// File: tb/tb_radix2_divider.sv
// Self-checking bench for radix2_divider: table-driven vectors, random
// vectors against language arithmetic, and hand-written cancel, hold and
// reset sequences. Expected results go through a scoreboard queue.

module tb_radix2_divider;

    logic        clock;
    logic        reset;
    logic        request_valid;
    logic        request_ready;
    logic        request_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        cancel;
    logic        result_valid;
    logic        result_ready;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        busy;

    radix2_divider #(.CPU_DATA_WIDTH(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .request_valid  (request_valid),
        .request_ready  (request_ready),
        .request_signed (request_signed),
        .dividend       (dividend),
        .divisor        (divisor),
        .cancel         (cancel),
        .result_valid   (result_valid),
        .result_ready   (result_ready),
        .quotient       (quotient),
        .remainder      (remainder),
        .busy           (busy)
    );

    // Clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs [NVEC];

    logic [63:0] exp_q [$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic sgn, input logic [31:0] a, input logic [31:0] b);
`ifdef DIVIDER_EARLY_FINISH_EN
        logic [31:0] aa;
        logic [31:0] bb;
        aa = (sgn && a[31]) ? (32'd0 - a) : a;
        bb = (sgn && b[31]) ? (32'd0 - b) : b;
        if ((b == 32'd0) || (aa < bb)) return 2;
        return 34;
`else
        return (sgn || a != b || a == b) ? 34 : 34;
`endif
    endfunction

    // Drive one request from a negedge, wait for the result, optionally hold
    // result_ready low for 'hold' cycles, then consume and check.
    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eq, input logic [31:0] er, input int hold);
        int lat;
        logic [63:0] e;
        request_valid  = 1'b1;
        request_signed = sgn;
        dividend       = a;
        divisor        = b;
        check("ready_before_accept", 32'(request_ready), 32'd1);
        @(posedge clock);
        exp_q.push_back({eq, er});
        @(negedge clock);
        request_valid  = 1'b0;
        request_signed = ~sgn;
        dividend       = $urandom;
        divisor        = $urandom;
        lat = 1;
        while (!result_valid && lat < 100) begin
            @(negedge clock);
            lat++;
        end
        if (!result_valid) begin
            check("result_timeout", 32'd0, 32'd1);
            void'(exp_q.pop_front());
            return;
        end
        check("latency", 32'(lat), 32'(exp_lat(sgn, a, b)));
        for (int i = 0; i < hold; i++) begin
            check("hold_valid", 32'(result_valid), 32'd1);
            check("hold_busy", 32'(busy), 32'd1);
            check("hold_req_ready", 32'(request_ready), 32'd0);
            check("hold_quotient", quotient, eq);
            @(negedge clock);
        end
        result_ready = 1'b1;
        if (exp_q.size() == 0) begin
            check("scoreboard_underflow", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check("quotient", quotient, e[63:32]);
            check("remainder", remainder, e[31:0]);
        end
        @(posedge clock);
        @(negedge clock);
        result_ready = 1'b0;
        check("post_ready", 32'(request_ready), 32'd1);
        check("post_valid", 32'(result_valid), 32'd0);
        check("post_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic [31:0] rq;
        logic [31:0] rr;
        logic saw;

        vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
        vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF};
        vecs[2]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1};
        vecs[3]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0};
        vecs[4]  = '{1'b0, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5};
        vecs[5]  = '{1'b1, 32'hFFFFFFFB,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFFB};
        vecs[6]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0};
        vecs[7]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000};
        vecs[8]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE};
        vecs[9]  = '{1'b0, 32'hFFFFFFF9,   32'd2,          32'h7FFFFFFC,   32'd1};
        vecs[10] = '{1'b0, 32'd3,          32'd10,         32'd0,          32'd3};
        vecs[11] = '{1'b1, 32'hFFFFFFFD,   32'd10,         32'd0,          32'hFFFFFFFD};
        vecs[12] = '{1'b0, 32'hDEADBEEF,   32'h00010000,   32'h0000DEAD,   32'h0000BEEF};

        // Reset
        reset          = 1'b1;
        request_valid  = 1'b0;
        request_signed = 1'b0;
        dividend       = '0;
        divisor        = '0;
        cancel         = 1'b0;
        result_ready   = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_req_ready", 32'(request_ready), 32'd1);
        check("reset_res_valid", 32'(result_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_quotient", quotient, 32'd0);
        check("reset_remainder", remainder, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // Table-driven vectors
        for (int i = 0; i < NVEC; i++) begin
            run_div(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, 0);
        end

        // Random unsigned vectors
        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = (i < 3) ? 32'($urandom_range(1, 65535)) : ($urandom | 32'd1);
            rq = ra / rb;
            rr = ra % rb;
            run_div(1'b0, ra, rb, rq, rr, 0);
        end

        // Random signed vectors (divisor nonzero, overflow excluded)
        for (int i = 0; i < 6; i++) begin
            sa = $signed($urandom);
            sb = (i < 3) ? $signed(32'($urandom_range(1, 1000)) ^ {32{i[0]}}) : $signed($urandom);
            if (sb == 0) sb = 3;
            if (sa == 32'sh80000000 && sb == -1) sb = 5;
            rq = sa / sb;
            rr = sa % sb;
            run_div(1'b1, sa, sb, rq, rr, 0);
        end

        // Hold result_ready low for 20 cycles in RETURN
        run_div(1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 20);

        // Cancel 10 cycles after accept
        request_valid  = 1'b1;
        request_signed = 1'b0;
        dividend       = 32'd100;
        divisor        = 32'd7;
        @(posedge clock);
        @(negedge clock);
        request_valid = 1'b0;
        repeat (9) @(negedge clock);
        cancel = 1'b1;
        @(posedge clock);
        @(negedge clock);
        cancel = 1'b0;
        check("cancel_req_ready", 32'(request_ready), 32'd1);
        check("cancel_busy", 32'(busy), 32'd0);
        check("cancel_res_valid", 32'(result_valid), 32'd0);
        saw = 1'b0;
        repeat (40) begin
            if (result_valid) saw = 1'b1;
            @(negedge clock);
        end
        check("cancel_no_result", 32'(saw), 32'd0);
        run_div(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 0);

        // Reset in the middle of DIVIDE, with a request presented during reset
        request_valid  = 1'b1;
        request_signed = 1'b1;
        dividend       = 32'hFFFFFF9C;
        divisor        = 32'd7;
        @(posedge clock);
        @(negedge clock);
        request_valid = 1'b0;
        repeat (15) @(negedge clock);
        check("pre_reset_busy", 32'(busy), 32'd1);
        reset          = 1'b1;
        request_valid  = 1'b1;
        dividend       = 32'd55;
        divisor        = 32'd5;
        @(posedge clock);
        @(negedge clock);
        check("midrst_req_ready", 32'(request_ready), 32'd1);
        check("midrst_res_valid", 32'(result_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_quotient", quotient, 32'd0);
        check("midrst_remainder", remainder, 32'd0);
        @(posedge clock);
        @(negedge clock);
        reset         = 1'b0;
        request_valid = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check("after_rst_not_accepted", 32'(busy), 32'd0);
        run_div(1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 0);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
